// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge detection per source, write-1-to-clear
// pending bits, per-source mask, fixed lowest-index priority and a
// three-state take/service handshake with the core. MASK, PEND and CAUSE
// live in the special-register space at selects 4, 5 and 6.
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            sr_ie,
  input  logic [15:0]     sr_sel,
  input  logic [15:0]     sr_in,
  output logic [15:0]     sr_out,
  input  logic            irq_ready,
  input  logic            iret,
  output logic            irq_out,
  output logic            in_handler
);

  localparam logic [15:0] SEL_MASK  = 16'd4;
  localparam logic [15:0] SEL_PEND  = 16'd5;
  localparam logic [15:0] SEL_CAUSE = 16'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SERVICE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [NSRC-1:0] prev_src;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic            cause_valid;
  logic [3:0]      cause_idx;

  logic [NSRC-1:0] edge_vec;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] take_vec;
  logic [NSRC-1:0] clr_vec;
  logic [3:0]      win_idx;
  logic            take;
  logic            mask_wr;
  logic            pend_wr;
  logic            unused_sr_in;

  // Bits of sr_in above NSRC carry nothing for this block.
  assign unused_sr_in = ^sr_in;

  assign mask_wr  = sr_ie && (sr_sel == SEL_MASK);
  assign pend_wr  = sr_ie && (sr_sel == SEL_PEND);
  assign edge_vec = src & ~prev_src;
  assign eligible = pend & mask;

  // Fixed priority: scanning from the top down leaves the lowest eligible index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = 4'(i);
    end
  end

  // One-hot of the source being taken this cycle, used to clear its pend bit.
  always_comb begin
    take_vec = '0;
    for (int i = 0; i < NSRC; i++) begin
      take_vec[i] = take && (win_idx == 4'(i));
    end
  end

  assign clr_vec = take_vec | (pend_wr ? sr_in[NSRC-1:0] : '0);

  // State register; reset drops in_handler immediately since it decodes state.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state and take decision; take is gated by a nonzero eligible set so a
  // mask or clear landing in ARM can never produce a spurious irq_out.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|eligible) state_n = S_ARM;
      end
      S_ARM: begin
        if (eligible == '0) begin
          state_n = S_IDLE;
        end else if (irq_ready) begin
          take    = 1'b1;
          state_n = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (iret) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign irq_out    = take;
  assign in_handler = (state == S_SERVICE);

  // Edge history, pending bits (a new edge beats any clear) and the mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_src <= '0;
      pend     <= '0;
      mask     <= '0;
    end else begin
      prev_src <= src;
      pend     <= (pend & ~clr_vec) | edge_vec;
      if (mask_wr) mask <= sr_in[NSRC-1:0];
    end
  end

  // CAUSE records the most recently taken source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_valid <= 1'b0;
      cause_idx   <= '0;
    end else if (take) begin
      cause_valid <= 1'b1;
      cause_idx   <= win_idx;
    end
  end

  // Register read mux; selects not owned here read as zero.
  always_comb begin
    sr_out = '0;
    unique case (sr_sel)
      SEL_MASK:  sr_out[NSRC-1:0] = mask;
      SEL_PEND:  sr_out[NSRC-1:0] = pend;
      SEL_CAUSE: sr_out = {cause_valid, 11'b0, cause_idx};
      default:   sr_out = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Stimulus pushes the edge number at which each
// interrupt take must commit; a monitor pops an entry whenever irq_out is seen
// and flags any irq_out nobody asked for. Register contents are checked
// against hand-computed constants.
module tb_irq_ctrl;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            sr_ie;
  logic [15:0]     sr_sel;
  logic [15:0]     sr_in;
  logic [15:0]     sr_out;
  logic            irq_ready;
  logic            iret;
  logic            irq_out;
  logic            in_handler;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .sr_ie      (sr_ie),
    .sr_sel     (sr_sel),
    .sr_in      (sr_in),
    .sr_out     (sr_out),
    .irq_ready  (irq_ready),
    .iret       (iret),
    .irq_out    (irq_out),
    .in_handler (in_handler)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    edge_no;
    string name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: irq_out is sampled mid-low-phase; the take commits on the next rising edge.
  always @(negedge clk) begin
    #2;
    if (irq_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_irq_out", {31'b0, irq_out}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({"take_edge_", e.name}, cyc + 1, e.edge_no);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] sel, input logic [15:0] val);
    sr_ie  = 1'b1;
    sr_sel = sel;
    sr_in  = val;
    tick();
    sr_ie  = 1'b0;
    sr_in  = '0;
  endtask

  task automatic rd(input logic [15:0] sel, input logic [15:0] exp, input string name);
    sr_sel = sel;
    #1;
    check(name, {16'b0, sr_out}, {16'b0, exp});
  endtask

  task automatic pulse(input logic [NSRC-1:0] bits);
    src = bits;
    tick();
    src = '0;
  endtask

  task automatic expect_take(input int edge_no, input string name);
    exp_t e;
    e.edge_no = edge_no;
    e.name    = name;
    sb.push_back(e);
  endtask

  task automatic do_iret();
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; src = '0; sr_ie = 1'b0; sr_sel = '0; sr_in = '0;
    irq_ready = 1'b1; iret = 1'b0;

    // Reset state.
    tick(); tick();
    rd(16'd4, 16'h0000, "rst_mask");
    rd(16'd5, 16'h0000, "rst_pend");
    rd(16'd6, 16'h0000, "rst_cause");
    check("rst_in_handler", {31'b0, in_handler}, 32'd0);
    check("rst_irq_out", {31'b0, irq_out}, 32'd0);
    rst = 1'b1;
    tick(); tick();

    // Basic take: three-edge latency, CAUSE, PEND cleared, handler entered.
    wr(16'd4, 16'h0005);
    rd(16'd7, 16'h0000, "unowned_sel_reads_zero");
    expect_take(cyc + 3, "t1");
    pulse(8'h04);
    tick(); tick();
    rd(16'd6, 16'h8002, "t1_cause");
    rd(16'd5, 16'h0000, "t1_pend");
    check("t1_in_handler", {31'b0, in_handler}, 32'd1);
    tick(); tick();
    check("t1_hold_handler", {31'b0, in_handler}, 32'd1);
    do_iret();
    check("t1_iret_exit", {31'b0, in_handler}, 32'd0);

    // Simultaneous sources: lowest index first, next one two edges after iret.
    wr(16'd4, 16'h00FF);
    expect_take(cyc + 3, "t2a");
    pulse(8'h0A);
    tick(); tick();
    rd(16'd6, 16'h8001, "t2_cause_first");
    rd(16'd5, 16'h0008, "t2_pend_after_first");
    tick(); tick(); tick();
    expect_take(cyc + 3, "t2b");
    do_iret();
    tick(); tick();
    rd(16'd6, 16'h8003, "t2_cause_second");
    rd(16'd5, 16'h0000, "t2_pend_after_second");
    do_iret();

    // No nesting: an edge during service waits in PEND until iret.
    expect_take(cyc + 3, "t3a");
    pulse(8'h40);
    tick(); tick();
    rd(16'd6, 16'h8006, "t3_cause_outer");
    pulse(8'h01);
    tick(); tick(); tick(); tick();
    rd(16'd5, 16'h0001, "t3_pend_held");
    check("t3_still_in_handler", {31'b0, in_handler}, 32'd1);
    expect_take(cyc + 3, "t3b");
    do_iret();
    tick(); tick();
    rd(16'd6, 16'h8000, "t3_cause_after_iret");
    rd(16'd5, 16'h0000, "t3_pend_cleared");
    do_iret();

    // Masked source accumulates; unmasking releases it.
    wr(16'd4, 16'h00EF);
    pulse(8'h10);
    tick(); tick(); tick(); tick();
    rd(16'd5, 16'h0010, "t4_pend_masked");
    check("t4_idle_while_masked", {31'b0, in_handler}, 32'd0);
    expect_take(cyc + 3, "t4_unmask");
    wr(16'd4, 16'h0010);
    tick(); tick();
    rd(16'd6, 16'h8004, "t4_cause");
    do_iret();

    // W1C while armed: back to idle with no irq_out once the core is ready.
    irq_ready = 1'b0;
    pulse(8'h10);
    tick(); tick(); tick();
    wr(16'd5, 16'h0010);
    irq_ready = 1'b1;
    tick(); tick(); tick(); tick();
    rd(16'd5, 16'h0000, "t4b_pend_cleared");
    check("t4b_no_handler", {31'b0, in_handler}, 32'd0);

    // Set beats W1C in the same cycle; repeated edges collapse to one bit.
    wr(16'd4, 16'h0000);
    src = 8'h20; sr_ie = 1'b1; sr_sel = 16'd5; sr_in = 16'h0020;
    tick();
    src = '0; sr_ie = 1'b0; sr_in = '0;
    rd(16'd5, 16'h0020, "t5_set_beats_clear");
    pulse(8'h20);
    tick();
    pulse(8'h20);
    tick();
    rd(16'd5, 16'h0020, "t5_collapse");
    wr(16'd5, 16'h0020);
    rd(16'd5, 16'h0000, "t5_w1c");

    // New edge on the source being taken keeps its pend bit.
    wr(16'd4, 16'h0001);
    expect_take(cyc + 3, "t6a");
    src = 8'h01; tick();
    src = 8'h00; tick();
    src = 8'h01; tick();
    src = 8'h00;
    rd(16'd5, 16'h0001, "t6_pend_retained");
    rd(16'd6, 16'h8000, "t6_cause");
    expect_take(cyc + 3, "t6b");
    do_iret();
    tick(); tick();
    rd(16'd5, 16'h0000, "t6_pend_after_second");
    do_iret();

    // Asynchronous reset mid-service, then a source high at release.
    wr(16'd4, 16'h00FF);
    expect_take(cyc + 3, "t7");
    pulse(8'h80);
    tick(); tick();
    check("t7_in_handler", {31'b0, in_handler}, 32'd1);
    rst = 1'b0;
    #1;
    check("t7_async_drop", {31'b0, in_handler}, 32'd0);
    rd(16'd4, 16'h0000, "t7_mask_reset");
    rd(16'd5, 16'h0000, "t7_pend_reset");
    rd(16'd6, 16'h0000, "t7_cause_reset");
    src = 8'h02;
    tick(); tick();
    rd(16'd5, 16'h0000, "t7_pend_held_in_reset");
    rst = 1'b1;
    tick();
    rd(16'd5, 16'h0002, "t7_high_at_release");
    src = '0;
    wr(16'd5, 16'h0002);
    tick(); tick(); tick();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
